wb_arbiter: RTL

- Multi-master arbiter in front of WB_intercon's master port.
- Lets the CPU and up to three further bus masters (disk DMA, UART loader, debug) share the single Wishbone slave bus.
- Round-robin grant, one transaction per grant, with a watchdog that terminates transactions no slave acknowledges.
- Downstream intercon, slaves and address map are unchanged.

---
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone multi-master arbiter with a watchdog that terminates unacknowledged cycles.
// Optional macro WB_ARB_LOCK_EN adds m_LOCK so one master can keep the bus across back-to-back cycles.
module wb_arbiter #(
  parameter int          N_MASTERS = 2,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    RSTN,
  input  logic [N_MASTERS-1:0]    m_STB,
  input  logic [N_MASTERS-1:0]    m_WE,
  input  logic [32*N_MASTERS-1:0] m_ADDR,
  input  logic [32*N_MASTERS-1:0] m_DAT_I,
`ifdef WB_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]    m_LOCK,
`endif
  output logic [N_MASTERS-1:0]    m_ACK,
  output logic [N_MASTERS-1:0]    m_ERR,
  output logic [31:0]             m_DAT_O,
  output logic                    bus_STB,
  output logic                    bus_WE,
  output logic [31:0]             bus_ADDR,
  output logic [31:0]             bus_DAT_O,
  input  logic [31:0]             bus_DAT_I,
  input  logic                    bus_ACK,
  output logic [1:0]              grant,
  output logic [7:0]              timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t               state;
  logic [15:0]          watchdog;
  logic [N_MASTERS-1:0] grant_oh;
  logic [1:0]           winner;
  logic                 found;
  int                   best_dist;
  logic                 lock_hold;
  logic [1:0]           next_owner;
  logic                 start;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_dat;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant == 2'(i)) grant_oh[i] = 1'b1;
    end
  end

  // Distance from the last owner decides priority; the last owner itself ranks last.
  always_comb begin
    winner    = grant;
    best_dist = N_MASTERS;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_STB[i] && (((i + 2*N_MASTERS - int'(grant) - 1) % N_MASTERS) < best_dist)) begin
        best_dist = (i + 2*N_MASTERS - int'(grant) - 1) % N_MASTERS;
        winner    = 2'(i);
      end
    end
    found = (best_dist < N_MASTERS);
  end

`ifdef WB_ARB_LOCK_EN
  logic lock_active;

  assign lock_hold = lock_active && (|(m_LOCK & m_STB & grant_oh));

  // Lock is armed from m_LOCK at release and survives only while the owner keeps requesting.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      lock_active <= 1'b0;
    end else if (state == RELEASE) begin
      lock_active <= |(m_LOCK & grant_oh);
    end else if (state == IDLE) begin
      lock_active <= lock_hold;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  assign next_owner = lock_hold ? grant : winner;
  assign start      = lock_hold | found;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dat  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (next_owner == 2'(i)) begin
        sel_we   = m_WE[i];
        sel_addr = m_ADDR[32*i +: 32];
        sel_dat  = m_DAT_I[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      m_ACK       <= '0;
      m_ERR       <= '0;
      m_DAT_O     <= '0;
      bus_STB     <= 1'b0;
      bus_WE      <= 1'b0;
      bus_ADDR    <= '0;
      bus_DAT_O   <= '0;
      grant       <= 2'(N_MASTERS - 1);
      timeout_cnt <= '0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_ACK <= '0;
          m_ERR <= '0;
          if (start) begin
            grant     <= next_owner;
            bus_STB   <= 1'b1;
            bus_WE    <= sel_we;
            bus_ADDR  <= sel_addr;
            bus_DAT_O <= sel_dat;
            state     <= BUSY;
          end
        end
        // A real acknowledge takes precedence over a watchdog expiry in the same cycle.
        BUSY: begin
          if (bus_ACK) begin
            m_ACK   <= grant_oh;
            m_DAT_O <= bus_DAT_I;
            bus_STB <= 1'b0;
            state   <= RELEASE;
          end else if (watchdog == WD_LAST) begin
            m_ACK   <= grant_oh;
            m_ERR   <= grant_oh;
            m_DAT_O <= ERR_DATA;
            bus_STB <= 1'b0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state   <= RELEASE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        RELEASE: begin
          m_ACK    <= '0;
          m_ERR    <= '0;
          watchdog <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
